// File: rtl/program_loader_ctrl.sv
// Load-then-run sequencer: streams instruction words, then data words, from a host
// word stream into the processor load port, then starts it and watches for its end.
module program_loader_ctrl #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_RUN    = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [31:0] host_data,
  output logic [31:0] new_instruction,
  output logic        load_valid,
  output logic        add_into,
  output logic        start_signal,
  input  logic        end_signal,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  error_code,
  output logic [31:0] run_cycles,
  output logic [3:0]  fsm_state
);

  // Host handshake: a word transfers on a rising edge where host_valid and
  // host_ready are both high; clear withdraws host_ready so no word is consumed.
  typedef enum logic [3:0] {
    S_HDR_I = 4'd0,
    S_INSTR = 4'd1,
    S_GAP1  = 4'd2,
    S_HDR_D = 4'd3,
    S_DATA  = 4'd4,
    S_GAP2  = 4'd5,
    S_RUN   = 4'd6,
    S_DONE  = 4'd7,
    S_ERROR = 4'd8
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] remaining;
  logic [15:0] gap_cnt;
  logic        xfer;
  logic        gap_last;
  logic [31:0] hdr_count;

  assign xfer      = host_valid & host_ready;
  assign gap_last  = (gap_cnt == 16'(GAP_CYCLES - 1));
  assign hdr_count = {16'd0, host_data[15:0]};
  assign fsm_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_HDR_I;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_HDR_I;
    end else begin
      case (state_q)
        S_HDR_I: if (xfer) begin
          if (hdr_count > 32'(IMEM_DEPTH)) state_d = S_ERROR;
          else if (hdr_count == 32'd0)     state_d = S_GAP1;
          else                             state_d = S_INSTR;
        end
        S_INSTR: if (xfer && remaining == 16'd1) state_d = S_GAP1;
        S_GAP1:  if (gap_last) state_d = S_HDR_D;
        S_HDR_D: if (xfer) begin
          if (hdr_count > 32'(DMEM_DEPTH)) state_d = S_ERROR;
          else if (hdr_count == 32'd0)     state_d = S_GAP2;
          else                             state_d = S_DATA;
        end
        S_DATA:  if (xfer && remaining == 16'd1) state_d = S_GAP2;
        S_GAP2:  if (gap_last) state_d = S_RUN;
        S_RUN: begin
          if (end_signal)                         state_d = S_DONE;
          else if (run_cycles >= 32'(MAX_RUN))    state_d = S_ERROR;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    host_ready   = 1'b0;
    start_signal = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    case (state_q)
      S_HDR_I: begin host_ready = ~clear; busy = 1'b0; end
      S_INSTR, S_HDR_D, S_DATA: host_ready = ~clear;
      S_RUN:   start_signal = 1'b1;
      S_DONE:  begin start_signal = 1'b1; busy = 1'b0; done = 1'b1; end
      S_ERROR: begin busy = 1'b0; error = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      new_instruction <= 32'd0;
      load_valid      <= 1'b0;
      add_into        <= 1'b0;
      error_code      <= 2'd0;
      run_cycles      <= 32'd0;
      remaining       <= 16'd0;
      gap_cnt         <= 16'd0;
    end else begin
      load_valid <= 1'b0;
      if (clear) begin
        add_into   <= 1'b0;
        error_code <= 2'd0;
        remaining  <= 16'd0;
        gap_cnt    <= 16'd0;
      end else begin
        if ((state_q == S_INSTR || state_q == S_DATA) && xfer) begin
          new_instruction <= host_data;
          load_valid      <= 1'b1;
          remaining       <= remaining - 16'd1;
        end
        if ((state_q == S_HDR_I || state_q == S_HDR_D) && xfer)
          remaining <= host_data[15:0];
        if ((state_q == S_GAP1 || state_q == S_GAP2) && !gap_last)
          gap_cnt <= gap_cnt + 16'd1;
        else
          gap_cnt <= 16'd0;
        // Switch memories one cycle into GAP1 so the last instruction strobe
        // (presented in GAP1's first cycle) still targets instruction memory.
        if (state_q == S_GAP1)
          add_into <= 1'b1;
        if (state_d == S_ERROR && state_q != S_ERROR)
          error_code <= (state_q == S_RUN) ? 2'd2 : 2'd1;
        if (state_q == S_GAP2 && state_d == S_RUN)
          run_cycles <= 32'd1;
        else if (state_q == S_RUN && state_d == S_RUN)
          run_cycles <= run_cycles + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader_ctrl.sv
// Randomized bench for program_loader_ctrl: expected load strobes are queued as
// streams are issued and popped by a monitor on every load_valid pulse.
module tb_program_loader_ctrl;
  localparam int IMEM = 8;
  localparam int DMEM = 8;
  localparam int GAP  = 2;
  localparam int MAXR = 16;

  logic        clk = 1'b0;
  logic        reset, clear, host_valid, host_ready, load_valid, add_into;
  logic        start_signal, end_signal, busy, done, error;
  logic [31:0] host_data, new_instruction, run_cycles;
  logic [1:0]  error_code;
  logic [3:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  logic [31:0] last_word;

  program_loader_ctrl #(.IMEM_DEPTH(IMEM), .DMEM_DEPTH(DMEM), .GAP_CYCLES(GAP), .MAX_RUN(MAXR)) dut (
    .clk(clk), .reset(reset), .clear(clear), .host_valid(host_valid), .host_ready(host_ready),
    .host_data(host_data), .new_instruction(new_instruction), .load_valid(load_valid),
    .add_into(add_into), .start_signal(start_signal), .end_signal(end_signal), .busy(busy),
    .done(done), .error(error), .error_code(error_code), .run_cycles(run_cycles),
    .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b1 && load_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: got word 0x%0h add_into %0b with nothing expected",
                 new_instruction, add_into);
      end else begin
        mon_e = exp_q.pop_front();
        check("load_word", new_instruction, mon_e[31:0]);
        check("load_add_into", 32'(add_into), 32'(mon_e[32]));
      end
    end
  end

  // driver tasks (called on a falling edge, return on a falling edge)
  task automatic send_word(input logic [31:0] w, input bit gappy, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    if (gappy) repeat ($urandom_range(0, 2)) @(negedge clk);
    host_data  = w;
    host_valid = 1'b1;
    while (!acc && waited < 200) begin
      #1 acc = host_ready;
      @(negedge clk);
      if (!acc) waited++;
    end
    host_valid = 1'b0;
    host_data  = 32'd0;
    if (!acc) check("host_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_stream(input int n_i, input int n_d, input bit gappy, output int hdr_d_wait);
    logic [31:0] iw[$];
    logic [31:0] dw[$];
    logic [31:0] d;
    int w;
    for (int i = 0; i < n_i; i++) begin
      d = $urandom; iw.push_back(d); exp_q.push_back({1'b0, d});
    end
    for (int i = 0; i < n_d; i++) begin
      d = $urandom; dw.push_back(d); exp_q.push_back({1'b1, d});
    end
    send_word({16'($urandom), 16'(n_i)}, gappy, w);
    foreach (iw[k]) begin send_word(iw[k], gappy, w); last_word = iw[k]; end
    send_word({16'($urandom), 16'(n_d)}, gappy, hdr_d_wait);
    foreach (dw[k]) begin send_word(dw[k], gappy, w); last_word = dw[k]; end
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (start_signal !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("start_rise", 32'(start_signal), 32'd1);
  endtask

  // Called in the first RUN cycle; end_signal is high during RUN cycle r.
  task automatic run_end(input int r);
    int c;
    check("run_first_count", run_cycles, 32'd1);
    c = 1;
    while (c < r) begin @(negedge clk); c++; end
    end_signal = 1'b1;
    @(negedge clk);
    end_signal = 1'b0;
    check("done_flag", 32'(done), 32'd1);
    check("done_run_cycles", run_cycles, 32'(r));
    check("done_start_held", 32'(start_signal), 32'd1);
    check("done_not_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("clear_load_valid", 32'(load_valid), 32'd0);
    check("clear_add_into", 32'(add_into), 32'd0);
    check("clear_start", 32'(start_signal), 32'd0);
    check("clear_done", 32'(done), 32'd0);
    check("clear_error", 32'(error), 32'd0);
    check("clear_error_code", 32'(error_code), 32'd0);
    check("clear_host_ready", 32'(host_ready), 32'd1);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_new_instruction"}, new_instruction, 32'd0);
    check({tag, "_load_valid"}, 32'(load_valid), 32'd0);
    check({tag, "_add_into"}, 32'(add_into), 32'd0);
    check({tag, "_start"}, 32'(start_signal), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_error_code"}, 32'(error_code), 32'd0);
    check({tag, "_run_cycles"}, run_cycles, 32'd0);
    check({tag, "_host_ready"}, 32'(host_ready), 32'd1);
  endtask

  initial begin
    int wd, n, t0, ni, nd, r;
    logic [31:0] kept;
    bit gappy;
    reset = 1'b0; clear = 1'b0; host_valid = 1'b0; host_data = 32'd0; end_signal = 1'b0;
    last_word = 32'd0;
    repeat (3) @(negedge clk);
    #1 check_idle_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // full stream, valid held
    send_stream(3, 2, 1'b0, wd);
    check("gap1_stall", 32'(wd), 32'(GAP));
    wait_start(n);
    check("gap2_cycles", 32'(n), 32'(GAP));
    run_end(10);
    check("queue_drained_t1", 32'(exp_q.size()), 32'd0);
    do_clear();
    check("clear_keeps_run_cycles", run_cycles, 32'd10);

    // same shape, host_valid toggling
    send_stream(3, 2, 1'b1, wd);
    wait_start(n);
    run_end(5);
    do_clear();

    // both headers zero
    t0 = cyc;
    send_stream(0, 0, 1'b0, wd);
    wait_start(n);
    check("zero_hdr_start_latency", 32'(cyc - t0), 32'(2 * GAP + 2));
    run_end(3);
    do_clear();

    // oversize instruction header
    send_word(32'(IMEM + 1) | {16'($urandom), 16'd0}, 1'b0, wd);
    check("err1_flag", 32'(error), 32'd1);
    check("err1_code", 32'(error_code), 32'd1);
    check("err1_host_ready", 32'(host_ready), 32'd0);
    check("err1_busy", 32'(busy), 32'd0);
    do_clear();

    // oversize data header
    send_word(32'd0, 1'b0, wd);
    send_word(32'(DMEM + 1), 1'b0, wd);
    check("err1d_code", 32'(error_code), 32'd1);
    check("err1d_flag", 32'(error), 32'd1);
    do_clear();

    // full-depth load, end in first RUN cycle
    send_stream(IMEM, DMEM, 1'b1, wd);
    wait_start(n);
    run_end(1);
    do_clear();

    // watchdog
    send_stream(1, 1, 1'b0, wd);
    wait_start(n);
    n = 0;
    while (error !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("wd_cycles_to_error", 32'(n), 32'(MAXR));
    check("wd_error_code", 32'(error_code), 32'd2);
    check("wd_run_cycles", run_cycles, 32'(MAXR));
    check("wd_start_low", 32'(start_signal), 32'd0);
    check("wd_done_low", 32'(done), 32'd0);
    do_clear();
    kept = run_cycles;
    check("wd_run_kept", kept, 32'(MAXR));

    // clear mid-INSTR
    send_word(32'd4, 1'b0, wd);
    for (int i = 0; i < 2; i++) begin
      last_word = $urandom;
      exp_q.push_back({1'b0, last_word});
      send_word(last_word, 1'b0, wd);
    end
    do_clear();
    check("midclr_busy", 32'(busy), 32'd0);
    check("midclr_word_held", new_instruction, last_word);
    check("midclr_run_kept", run_cycles, 32'(MAXR));
    send_stream(2, 3, 1'b1, wd);
    wait_start(n);
    run_end(7);
    do_clear();

    // reset mid-DATA
    send_word(32'd2, 1'b0, wd);
    for (int i = 0; i < 2; i++) begin
      last_word = $urandom; exp_q.push_back({1'b0, last_word}); send_word(last_word, 1'b0, wd);
    end
    send_word(32'd3, 1'b0, wd);
    last_word = $urandom; exp_q.push_back({1'b1, last_word}); send_word(last_word, 1'b0, wd);
    #2 reset = 1'b0;
    #1 check_idle_zero("midrst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_stream(4, 4, 1'b0, wd);
    wait_start(n);
    run_end(12);
    do_clear();

    // randomized streams
    for (int it = 0; it < 8; it++) begin
      ni = $urandom_range(0, IMEM);
      nd = $urandom_range(0, DMEM);
      gappy = 1'($urandom_range(0, 1));
      r = $urandom_range(1, MAXR - 1);
      send_stream(ni, nd, gappy, wd);
      wait_start(n);
      run_end(r);
      do_clear();
    end

    repeat (3) @(negedge clk);
    check("queue_drained_final", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
